// File: rtl/calculate_noise_power.sv
// calculate_noise_power: second pass of the SNR noise path. Re-reads the
// stored noise samples, accumulates (x - mean)^2 and divides by the sample
// count to produce the noise variance.
module calculate_noise_power #(
  parameter int DATA_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 5968,
  parameter int ADDR_WIDTH   = 13
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic signed [DATA_WIDTH-1:0]           noise_mean,
  output logic                                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                  mem_addr,
  input  logic signed [DATA_WIDTH-1:0]           mem_rd_data,
  output logic [2*DATA_WIDTH+2+ADDR_WIDTH-1:0]   sq_sum,
  output logic [2*DATA_WIDTH+1:0]                noise_power,
  output logic                                   busy,
  output logic                                   done_noise_power
);

  localparam int DIFF_W = DATA_WIDTH + 1;
  localparam int SQ_W   = 2 * DATA_WIDTH + 2;
  localparam int SUM_W  = SQ_W + ADDR_WIDTH;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] READ   = 3'd1;
  localparam logic [2:0] DRAIN  = 3'd2;
  localparam logic [2:0] DIVIDE = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMORY_DEPTH - 1);
  localparam logic [SUM_W-1:0]      DEPTH_DIV = SUM_W'(MEMORY_DEPTH);

  // Sign-extended subtraction; one extra bit means it can never overflow.
  function automatic logic signed [DIFF_W-1:0] sub_ext(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [DIFF_W-1:0] ae;
    logic signed [DIFF_W-1:0] be;
    ae = {a[DATA_WIDTH-1], a};
    be = {b[DATA_WIDTH-1], b};
    return ae - be;
  endfunction

  // Square of a difference; always non-negative, so the result is unsigned.
  function automatic logic [SQ_W-1:0] square(input logic signed [DIFF_W-1:0] d);
    logic signed [SQ_W-1:0] de;
    logic signed [SQ_W-1:0] p;
    de = {{(SQ_W-DIFF_W){d[DIFF_W-1]}}, d};
    p  = de * de;
    return p;
  endfunction

  // Truncating divide by the sample count; the quotient always fits SQ_W bits.
  function automatic logic [SQ_W-1:0] divide_depth(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] q;
    q = s / DEPTH_DIV;
    return q[SQ_W-1:0];
  endfunction

  logic [2:0]               state;
  logic                     vld_p0;
  logic                     vld_p1;
  logic signed [DATA_WIDTH-1:0] mean_q;
  logic signed [DIFF_W-1:0] diff_p1;
  logic [SQ_W-1:0]          sq_p1;
  logic                     accept;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign busy   = (state == READ) || (state == DRAIN) || (state == DIVIDE);

  // Mean is captured once per pass, on the accepted start.
  always_ff @(posedge clk) begin
    if (accept) mean_q <= noise_mean;
  end

  // ---- S1: read data -> registered deviation from the mean ----
  always_ff @(posedge clk) begin
    if (vld_p0) diff_p1 <= sub_ext(mem_rd_data, mean_q);
  end

  // ---- S2: squared deviation feeds the accumulator ----
  assign sq_p1 = square(diff_p1);

  // Control FSM, read address generation, valid pipeline and accumulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      mem_rd_en        <= 1'b0;
      mem_addr         <= '0;
      vld_p0           <= 1'b0;
      vld_p1           <= 1'b0;
      sq_sum           <= '0;
      noise_power      <= '0;
      done_noise_power <= 1'b0;
    end else begin
      vld_p0 <= mem_rd_en;
      vld_p1 <= vld_p0;
      if (vld_p1) sq_sum <= sq_sum + SUM_W'(sq_p1);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= READ;
            mem_rd_en        <= 1'b1;
            mem_addr         <= '0;
            sq_sum           <= '0;
            done_noise_power <= 1'b0;
          end
        end
        READ: begin
          if (mem_addr == LAST_ADDR) begin
            state     <= DRAIN;
            mem_rd_en <= 1'b0;
          end else begin
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          // With vld_p0 clear the last sample sits in S1 and is summed on
          // this edge, so DIVIDE sees the final sq_sum.
          if (!vld_p0) state <= DIVIDE;
        end
        DIVIDE: begin
          noise_power      <= divide_depth(sq_sum);
          done_noise_power <= 1'b1;
          state            <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calculate_noise_power.sv
// Directed bench for calculate_noise_power: a small-depth instance for the
// hand-computed cases and a default-depth instance driven with a ramp.
module tb_calculate_noise_power;

  localparam int DW = 16;
  localparam int AW = 13;
  localparam int N4 = 4;
  localparam int NB = 5968;
  localparam int SW = 2*DW+2+AW;
  localparam int PW = 2*DW+2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start4, startb;
  logic signed [DW-1:0] mean4, meanb, rd4, rdb;
  logic en4, enb;
  logic [AW-1:0] addr4, addrb;
  logic [SW-1:0] sq4, sqb;
  logic [PW-1:0] pw4, pwb;
  logic busy4, busyb, done4, doneb;

  logic signed [DW-1:0] ram4 [0:3];
  logic signed [DW-1:0] ramb [0:8191];

  int checks = 0;
  int failures = 0;
  longint exp_sq4 = 0;
  longint exp_pw4 = 0;
  bit mon_en = 1'b0;

  calculate_noise_power #(.DATA_WIDTH(DW), .MEMORY_DEPTH(N4), .ADDR_WIDTH(AW)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .noise_mean(mean4),
    .mem_rd_en(en4), .mem_addr(addr4), .mem_rd_data(rd4),
    .sq_sum(sq4), .noise_power(pw4), .busy(busy4), .done_noise_power(done4)
  );

  calculate_noise_power #(.DATA_WIDTH(DW), .MEMORY_DEPTH(NB), .ADDR_WIDTH(AW)) dutb (
    .clk(clk), .reset(reset), .start(startb), .noise_mean(meanb),
    .mem_rd_en(enb), .mem_addr(addrb), .mem_rd_data(rdb),
    .sq_sum(sqb), .noise_power(pwb), .busy(busyb), .done_noise_power(doneb)
  );

  // Noise buffer RAMs: registered read, one cycle latency.
  always @(posedge clk) begin
    if (en4) rd4 <= ram4[addr4[1:0]];
    if (enb) rdb <= ramb[addrb];
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain sum of squared deviations over the whole buffer.
  function automatic longint model_sq(input bit big, input longint mean);
    longint acc;
    longint d;
    int n;
    acc = 0;
    n = big ? NB : N4;
    for (int i = 0; i < n; i++) begin
      d = (big ? longint'(ramb[i]) : longint'(ram4[i])) - mean;
      acc += d * d;
    end
    return acc;
  endfunction

  // Whenever a result is flagged done it must match the model for that pass.
  always @(negedge clk) begin
    if (mon_en && done4) begin
      check("mon_sq_sum", longint'(sq4), exp_sq4);
      check("mon_noise_power", longint'(pw4), exp_pw4);
    end
  end

  task automatic set_ram4(input int a, input int b, input int c, input int d);
    ram4[0] = DW'(a); ram4[1] = DW'(b); ram4[2] = DW'(c); ram4[3] = DW'(d);
  endtask

  task automatic run4(input logic signed [DW-1:0] mean, input int pa, input int pb,
                      input longint lit_sq, input longint lit_pw, input string tag);
    longint esq;
    int done_at;
    done_at = -1;
    esq = model_sq(1'b0, longint'(mean));
    check({tag, "_model_sq"}, esq, lit_sq);
    check({tag, "_model_pw"}, esq / N4, lit_pw);
    @(posedge clk); #1;
    mean4 = mean;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    exp_sq4 = esq;
    exp_pw4 = esq / N4;
    for (int k = 1; k <= 30 && done_at < 0; k++) begin
      @(negedge clk);
      start4 = (k == pa) || (k == pb);
      if (k <= N4) begin
        check({tag, "_rd_en"}, longint'(en4), 1);
        check({tag, "_addr"}, longint'(addr4), k - 1);
      end
      if (k == N4 + 1) begin
        check({tag, "_rd_en_off"}, longint'(en4), 0);
        check({tag, "_addr_hold"}, longint'(addr4), N4 - 1);
      end
      if (k == N4 + 3) check({tag, "_sq_final"}, longint'(sq4), esq);
      if (done4) done_at = k;
      else check({tag, "_busy"}, longint'(busy4), 1);
    end
    start4 = 1'b0;
    check({tag, "_done_cycle"}, done_at, N4 + 4);
    check({tag, "_sq_sum"}, longint'(sq4), lit_sq);
    check({tag, "_noise_power"}, longint'(pw4), lit_pw);
    check({tag, "_busy_end"}, longint'(busy4), 0);
  endtask

  task automatic reset4_at(input logic signed [DW-1:0] mean, input int rc, input string tag);
    @(posedge clk); #1;
    mean4 = mean;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    exp_sq4 = model_sq(1'b0, longint'(mean));
    exp_pw4 = exp_sq4 / N4;
    for (int k = 1; k <= rc; k++) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check({tag, "_rst_rd_en"}, longint'(en4), 0);
    check({tag, "_rst_addr"}, longint'(addr4), 0);
    check({tag, "_rst_sq_sum"}, longint'(sq4), 0);
    check({tag, "_rst_noise_power"}, longint'(pw4), 0);
    check({tag, "_rst_busy"}, longint'(busy4), 0);
    check({tag, "_rst_done"}, longint'(done4), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check({tag, "_idle_busy"}, longint'(busy4), 0);
    check({tag, "_idle_rd_en"}, longint'(en4), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    longint esq;
    int done_at;
    reset = 1'b0;
    start4 = 1'b0;
    startb = 1'b0;
    mean4 = '0;
    meanb = '0;
    set_ram4(0, 0, 0, 0);
    for (int i = 0; i < 8192; i++) ramb[i] = DW'(i * 7 - 20000);
    #1;
    check("reset_rd_en", longint'(en4), 0);
    check("reset_addr", longint'(addr4), 0);
    check("reset_sq_sum", longint'(sq4), 0);
    check("reset_noise_power", longint'(pw4), 0);
    check("reset_busy", longint'(busy4), 0);
    check("reset_done", longint'(done4), 0);
    check("reset_done_big", longint'(doneb), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;

    set_ram4(10, 20, 30, 40);
    run4(16'sd25, -1, -1, 500, 125, "t1");

    set_ram4(0, 0, 0, 1);
    run4(16'sd0, -1, -1, 1, 0, "t2a");
    set_ram4(7, 7, 7, 7);
    run4(16'sd7, -1, -1, 0, 0, "t2b");

    set_ram4(-32768, -32768, -32768, -32768);
    run4(16'sd32767, -1, -1, 64'd17179344900, 64'd4294836225, "t3");

    set_ram4(10, 20, 30, 40);
    run4(16'sd25, 2, 5, 500, 125, "t4");

    reset4_at(16'sd25, 3, "t5a");
    reset4_at(16'sd25, 6, "t5b");
    run4(16'sd25, -1, -1, 500, 125, "t5");

    run4(16'sd20, -1, -1, 600, 150, "t6");

    // Full-depth pass over a ramp.
    esq = model_sq(1'b1, -123);
    done_at = -1;
    @(posedge clk); #1;
    meanb = -16'sd123;
    startb = 1'b1;
    @(posedge clk); #1;
    startb = 1'b0;
    for (int k = 1; k <= NB + 20 && done_at < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("big_rd_en", longint'(enb), 1);
        check("big_addr_first", longint'(addrb), 0);
      end
      if (k == NB) check("big_addr_last", longint'(addrb), NB - 1);
      if (k == NB + 3) check("big_sq_final", longint'(sqb), esq);
      if (doneb) done_at = k;
    end
    check("big_done_cycle", done_at, NB + 4);
    check("big_sq_sum", longint'(sqb), esq);
    check("big_noise_power", longint'(pwb), esq / NB);
    check("big_busy_end", longint'(busyb), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
